serialsubtractor_x: RTL



---
 rtl/serialarith_pkg.sv | 15 +
 rtl/fullsubtractor_1.sv | 14 +
 rtl/serialsubtractor_x.sv | 105 ++++++++++
 3 files changed

// File: rtl/serialarith_pkg.sv
// Shared encodings and sizing helpers for the bit-serial arithmetic blocks.
package serialarith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A counter must be at least one bit wide, even for a single-bit chain.
  function automatic int cntwidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fullsubtractor_1.sv
// Single-bit full subtractor cell: d = x - y - bin, bout set on underflow.
// Purely combinational; zero latency, no flow control.
module fullsubtractor_1 (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serialsubtractor_x.sv
// Bit-serial unsigned subtractor X - Y - Borrowin, LSB first, one bit per clk1 edge.
// Result arrives chainnumber+1 cycles after an accepted start; start is ignored while busy.
module serialsubtractor_x
  import serialarith_pkg::*;
#(
  parameter int chainnumber = 8
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [chainnumber-1:0] X,
  input  logic [chainnumber-1:0] Y,
  input  logic                   Borrowin,
  output logic                   busy,
  output logic                   done,
  output logic [chainnumber-1:0] Difference,
  output logic                   Borrowout
);

  localparam int cw = cntwidth(chainnumber);

  state_t                 state_q, state_d;
  logic [cw-1:0]          cnt_q;
  logic [chainnumber-1:0] xs_q, ys_q, diff_q, diff_next;
  logic                   b_q, bout_q;
  logic                   d, bnext;
  logic                   last, accept;

  fullsubtractor_1 u_cell (
    .x    (xs_q[0]),
    .y    (ys_q[0]),
    .bin  (b_q),
    .d    (d),
    .bout (bnext)
  );

  // New bit enters from the MSB side so bit i lands at position i after the last shift.
  generate
    if (chainnumber == 1) begin : g_one
      assign diff_next = d;
    end else begin : g_many
      assign diff_next = {d, diff_q[chainnumber-1:1]};
    end
  endgenerate

  assign last = (cnt_q == cw'(chainnumber - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      b_q     <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        xs_q  <= X;
        ys_q  <= Y;
        b_q   <= Borrowin;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        xs_q   <= xs_q >> 1;
        ys_q   <= ys_q >> 1;
        b_q    <= bnext;
        diff_q <= diff_next;
        if (last) bout_q <= bnext;
        else      cnt_q  <= cnt_q + cw'(1);
      end
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign Difference = diff_q;
  assign Borrowout  = bout_q;

endmodule
